// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: state encoding and widths.
package pipe_skid_reg_pkg;

  localparam int unsigned ST_W = 2;

  // EMPTY: nothing held; FULL: main register valid; SKID: main + skid both valid.
  // Encoding 2'd3 is unused and recovers to EMPTY.
  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } st_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Enabled D register with synchronous active-high reset to RESET_VAL.
module pipe_data_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Load the new value only when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop; reset wins over any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, a one-entry skid buffer so
// in_ready comes straight from a flop, and a synchronous flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  st_e              state_d;
  st_e              state_q;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic             main_sel_skid;
  logic [WIDTH-1:0] main_in;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // All outputs come from the state flop or the main data flop only.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_SKID);
  assign occ       = state_q;
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and register-load decode; flush empties the stage without touching data.
  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    skid_en       = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_en = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            state_d = ST_FULL;
            main_en = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled: park the new word in the skid register.
            state_d = ST_SKID;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            // Promote the parked word so FIFO order is preserved.
            state_d       = ST_FULL;
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Main register source: fresh upstream data or the parked skid word.
  always_comb begin
    main_in = in_data;
    if (main_sel_skid) begin
      main_in = skid_q;
    end else begin
      main_in = in_data;
    end
  end

  // State register; reset has priority over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main_reg (
    .clk(clk),
    .rst(rst),
    .en (main_en),
    .d  (main_in),
    .q  (main_q)
  );

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid_reg (
    .clk(clk),
    .rst(rst),
    .en (skid_en),
    .d  (in_data),
    .q  (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomized run
// against a two-deep FIFO reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;

  logic [7:0]  in_data8;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  out_data8;
  logic [1:0]  occ8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stage behaves as a FIFO of capacity two.
  logic [31:0] mq[$];

  assign in_data8 = in_data[7:0];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'd0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .occ(occ8)
  );

  // One clock: compute handshakes from model state, update model at the edge,
  // then settle 1 time unit past the edge before anyone samples.
  task automatic tick();
    bit in_f;
    bit out_f;
    in_f  = in_valid && (mq.size() < 2);
    out_f = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_data8 !== 8'hA5) begin n_fail++; $display("FAIL reset_out_data8 got %h want a5", out_data8); end
    n_checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || occ8 !== 2'd0) begin
      n_fail++; $display("FAIL reset_dut8_ctrl got rdy=%0b vld=%0b occ=%0d want 1 0 0", in_ready8, out_valid8, occ8);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a [3];
    a[0] = 32'hA1A1_0001; a[1] = 32'hA2A2_0002; a[2] = 32'hA3A3_0003;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = a[i];
      tick();
      n_checks++; if (out_data !== a[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, a[i]); end
      n_checks++; if (occ !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b want 1 1", i, occ, in_ready);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got occ=%0d vld=%0b want 0 0", occ, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1;
    tick();
    n_checks++; if (occ !== 2'd1 || out_data !== 32'hB1) begin n_fail++; $display("FAIL bp_first got occ=%0d data=%h want 1 b1", occ, out_data); end
    in_data = 32'hB2;
    tick();
    n_checks++; if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hB1) begin
      n_fail++; $display("FAIL bp_skid got occ=%0d rdy=%0b data=%h want 2 0 b1", occ, in_ready, out_data);
    end
    in_data = 32'hB3;
    tick();
    n_checks++; if (occ !== 2'd2 || out_data !== 32'hB1) begin n_fail++; $display("FAIL bp_hold got occ=%0d data=%h want 2 b1", occ, out_data); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (occ !== 2'd1 || out_data !== 32'hB2 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_rel1 got occ=%0d data=%h rdy=%0b want 1 b2 1", occ, out_data, in_ready);
    end
    tick();
    n_checks++; if (occ !== 2'd1 || out_data !== 32'hB3) begin n_fail++; $display("FAIL bp_rel2 got occ=%0d data=%h want 1 b3", occ, out_data); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL bp_drain got occ=%0d want 0", occ); end
  endtask

  task automatic test_flush_skid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h0000_00F1; tick();
    in_data = 32'h0000_00F2; tick();
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL fs_fill got occ=%0d want 2", occ); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fs_flush got occ=%0d vld=%0b rdy=%0b want 0 0 1", occ, out_valid, in_ready);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00C1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hC1) begin n_fail++; $display("FAIL fs_next got vld=%0b data=%h want 1 c1", out_valid, out_data); end
    tick();
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
    tick();
    in_data = 32'hD1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ff_discard got occ=%0d vld=%0b want 0 0", occ, out_valid); end
    tick();
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL ff_stay got occ=%0d want 0", occ); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hE1; tick();
    in_data = 32'hE2; tick();
    n_checks++; if (occ8 !== 2'd2) begin n_fail++; $display("FAIL rm_fill got occ8=%0d want 2", occ8); end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      n_fail++; $display("FAIL rm_dut got occ=%0d vld=%0b rdy=%0b data=%h want 0 0 1 0", occ, out_valid, in_ready, out_data);
    end
    n_checks++; if (out_data8 !== 8'hA5 || occ8 !== 2'd0) begin n_fail++; $display("FAIL rm_dut8 got data=%h occ=%0d want a5 0", out_data8, occ8); end
  endtask

  task automatic test_random();
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 199) == 0);
      if (in_valid && in_ready && !flush) sent++;
      if (out_valid && out_ready && !flush) got++;
      tick();
      n_checks++; if (occ !== mq.size()) begin n_fail++; $display("FAIL rnd_occ c=%0d got %0d want %0d", c, occ, mq.size()); end
      n_checks++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        n_fail++; $display("FAIL rnd_hs c=%0d got vld=%0b rdy=%0b want size %0d", c, out_valid, in_ready, mq.size());
      end
      if (mq.size() > 0) begin
        n_checks++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, mq[0]); end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (occ !== 2'd0 || got == 0 || sent == 0) begin
      n_fail++; $display("FAIL rnd_end got occ=%0d sent=%0d recv=%0d want occ 0 and traffic", occ, sent, got);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_skid();
    test_flush_fire();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
